// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch, decode, execute and
// writeback over a shared ALU and memory port, trapping on illegal encodings or memory timeout.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_state;
  logic          timeout;
  logic [2:0]    alu_dec;
  logic          alu_f3_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q >= CW'(TIMEOUT_CYCLES));

  always_comb begin
    alu_dec   = 3'b000;
    alu_f3_ok = 1'b1;
    case (funct3)
      3'b000:  alu_dec = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    imm_src     = 3'b000;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal     = 1'b0;

    case (op)
      7'b0100011: imm_src = 3'b001;
      7'b1100011: imm_src = 3'b010;
      7'b0110111: imm_src = 3'b011;
      7'b1101111: imm_src = 3'b100;
      default:    imm_src = 3'b000;
    endcase

    // Stall counter only runs while a memory handshake is outstanding.
    if (mem_state && !mem_ready && !timeout) cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (timeout) begin
          state_d = S_TRAP;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          7'b1101111:             state_d = S_JAL;
          7'b0110111:             state_d = S_LUI;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (timeout)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        if (timeout) begin
          state_d = S_TRAP;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = alu_dec;
        state_d     = alu_f3_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero ^ funct3[0];
        state_d     = S_FETCH;
      end
      S_LUI: begin
        result_src = 2'b11;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase

    if (reset) begin
      imm_src     = 3'b000;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = 3'b000;
      result_src  = 2'b00;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench: instruction-level stimulus pushes the expected per-cycle
// control word; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011, OP_SW  = 7'b0100011, OP_R   = 7'b0110011,
                         OP_I   = 7'b0010011, OP_BR  = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_LUI = 7'b0110111;
  localparam int P_FETCH = 0, P_DEC = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4, P_MEMWR = 5,
                 P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_JAL = 9, P_BR = 10, P_LUI = 11, P_TRAP = 12;
  localparam int TMO = 16;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] imm;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] alu;
    logic [1:0] rs;
    logic       adr, irw, pcw, rw, mw, ill;
  } ctl_t;

  logic       clk = 1'b0, reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [2:0] imm_src, alu_control;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, ir_write, pc_write, reg_write, mem_write, illegal;
  logic [3:0] state;

  logic [6:0] t_op = '0;
  logic [2:0] t_f3 = '0;
  logic       t_f7 = 1'b0, t_zero = 1'b0;

  ctl_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .result_src(result_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .mem_write(mem_write),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OP_SW:   return 3'b001;
      OP_BR:   return 3'b010;
      OP_LUI:  return 3'b011;
      OP_JAL:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu_of();
    case (t_f3)
      3'd0:    return (t_op[5] && t_f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for one cycle of a given instruction step.
  function automatic ctl_t model(input int ph, input logic mr, input logic to);
    ctl_t c;
    c = '0;
    c.st  = ph[3:0];
    c.imm = imm_of(t_op);
    case (ph)
      P_FETCH:  begin c.b = 2'b10; c.rs = 2'b10; c.irw = mr & ~to; c.pcw = mr & ~to; end
      P_DEC:    begin c.a = 2'b01; c.b = 2'b01; end
      P_MEMADR: begin c.a = 2'b10; c.b = 2'b01; end
      P_MEMRD:  c.adr = 1'b1;
      P_MEMWB:  begin c.rs = 2'b01; c.rw = 1'b1; end
      P_MEMWR:  begin c.adr = 1'b1; c.mw = ~to; end
      P_EXR:    begin c.a = 2'b10; c.alu = alu_of(); end
      P_EXI:    begin c.a = 2'b10; c.b = 2'b01; c.alu = alu_of(); end
      P_ALUWB:  c.rw = 1'b1;
      P_JAL:    begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1'b1; end
      P_BR:     begin c.a = 2'b10; c.alu = 3'b001; c.pcw = t_zero ^ t_f3[0]; end
      P_LUI:    begin c.rs = 2'b11; c.rw = 1'b1; end
      P_TRAP:   c.ill = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic cyc(input int ph, input logic mr, input logic rst, input logic to);
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr;
    op = t_op; funct3 = t_f3; funct7b5 = t_f7; zero = t_zero;
    sb_q.push_back(rst ? ctl_t'('0) : model(ph, mr, to));
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) cyc(P_TRAP, rbit(), 1'b0, 1'b0);
    cyc(P_FETCH, 1'b0, 1'b1, 1'b0);
  endtask

  // Handshake step with n stall cycles; returns 1 when the stall ran into the timeout.
  task automatic mem_step(input int ph, input int n, output bit trapped);
    for (int i = 0; i < n && i < TMO; i++) cyc(ph, 1'b0, 1'b0, 1'b0);
    trapped = (n >= TMO);
    cyc(ph, 1'b1, 1'b0, trapped);
    if (trapped) trap_tail();
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int s_f, input int s_m);
    bit tr;
    t_op = o; t_f3 = f3; t_f7 = f7; t_zero = z;
    $display("instr op=%b f3=%b f7=%b zero=%b fetch_stall=%0d mem_stall=%0d", o, f3, f7, z, s_f, s_m);
    mem_step(P_FETCH, s_f, tr);
    if (tr) return;
    cyc(P_DEC, rbit(), 1'b0, 1'b0);
    case (o)
      OP_LW, OP_SW: begin
        cyc(P_MEMADR, rbit(), 1'b0, 1'b0);
        if (o[5] == 1'b0) begin
          mem_step(P_MEMRD, s_m, tr);
          if (!tr) cyc(P_MEMWB, rbit(), 1'b0, 1'b0);
        end else begin
          mem_step(P_MEMWR, s_m, tr);
        end
      end
      OP_R, OP_I: begin
        cyc((o == OP_R) ? P_EXR : P_EXI, rbit(), 1'b0, 1'b0);
        if (f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) cyc(P_ALUWB, rbit(), 1'b0, 1'b0);
        else trap_tail();
      end
      OP_BR:   if (f3 inside {3'd0, 3'd1}) cyc(P_BR, rbit(), 1'b0, 1'b0); else trap_tail();
      OP_JAL:  begin cyc(P_JAL, rbit(), 1'b0, 1'b0); cyc(P_ALUWB, rbit(), 1'b0, 1'b0); end
      OP_LUI:  cyc(P_LUI, rbit(), 1'b0, 1'b0);
      default: trap_tail();
    endcase
  endtask

  always @(negedge clk) begin
    ctl_t got, exp_c;
    if (sb_q.size() > 0) begin
      exp_c = sb_q.pop_front();
      got = '{st: state, imm: imm_src, a: alu_src_a, b: alu_src_b, alu: alu_control,
              rs: result_src, adr: adr_src, irw: ir_write, pcw: pc_write, rw: reg_write,
              mw: mem_write, ill: illegal};
      checks++;
      if (got !== exp_c) begin
        failures++;
        $display("FAIL ctl t=%0t got st=%0d imm=%b a=%b b=%b alu=%b rs=%b adr/ir/pc/rw/mw/ill=%b%b%b%b%b%b exp st=%0d imm=%b a=%b b=%b alu=%b rs=%b adr/ir/pc/rw/mw/ill=%b%b%b%b%b%b",
                 $time, got.st, got.imm, got.a, got.b, got.alu, got.rs, got.adr, got.irw,
                 got.pcw, got.rw, got.mw, got.ill, exp_c.st, exp_c.imm, exp_c.a, exp_c.b,
                 exp_c.alu, exp_c.rs, exp_c.adr, exp_c.irw, exp_c.pcw, exp_c.rw, exp_c.mw,
                 exp_c.ill);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [7];
    logic [2:0] alu_f3 [4];
    logic [6:0] o;
    logic [2:0] f3;
    int k, s_f, s_m, wait_cnt;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI};
    alu_f3 = '{3'd0, 3'd2, 3'd6, 3'd7};

    cyc(P_FETCH, 1'b0, 1'b1, 1'b0);
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(OP_BR,  3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR,  3'd1, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR,  3'd1, 1'b0, 1'b0, 1, 0);
    run_instr(OP_JAL, 3'd5, 1'b1, 1'b0, 0, 0);
    run_instr(OP_LUI, 3'd3, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R,   3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I,   3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_R,   3'd4, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BR,  3'd4, 1'b0, 1'b0, 0, 0);
    run_instr(7'h7f,  3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, TMO - 1, TMO - 1);
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, TMO, 0);
    run_instr(OP_LW,  3'd2, 1'b0, 1'b0, 0, TMO);
    run_instr(OP_SW,  3'd2, 1'b0, 1'b0, 2, TMO);

    // Reset raised between edges while in MEMADR must clear state immediately.
    t_op = OP_LW; t_f3 = 3'd2; t_f7 = 1'b0; t_zero = 1'b0;
    $display("instr op=%b reset asserted in MEMADR", OP_LW);
    cyc(P_FETCH, 1'b1, 1'b0, 1'b0);
    cyc(P_DEC, 1'b1, 1'b0, 1'b0);
    cyc(P_MEMADR, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({state, ir_write, pc_write, reg_write, mem_write, illegal} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset got state=%0d ir/pc/rw/mw/ill=%b%b%b%b%b exp state=0 all 0",
               state, ir_write, pc_write, reg_write, mem_write, illegal);
    end
    cyc(P_FETCH, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 70; n++) begin
      k = $urandom_range(0, 7);
      o = (k == 7) ? 7'($urandom_range(0, 127)) : ops[k];
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        if (o == OP_R || o == OP_I) f3 = alu_f3[$urandom_range(0, 3)];
        if (o == OP_BR)             f3 = 3'($urandom_range(0, 1));
      end
      s_f = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, 3);
      s_m = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 4);
      run_instr(o, f3, rbit(), rbit(), s_f, s_m);
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
